// File: rtl/mem_wb_stage_hs_if.sv
// rtl/mem_wb_stage_hs_if.sv - data memory request/acknowledge bus
interface mem_wb_stage_hs_if #(
  parameter int DATA_W = 16
);
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_stage_hs.sv
// rtl/mem_wb_stage_hs.sv - memory stage with req/ack data memory and MEM/WB register
module mem_wb_stage_hs #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int STORE_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                IRegWrite,
  input  logic [STORE_W-1:0]  IRegStore,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic                MemByte,
  input  logic                MemSigned,
  input  logic [DATA_W-1:0]   IPCP2,
  input  logic [DATA_W-1:0]   IALUResult,
  input  logic [DATA_W-1:0]   thirdArg,
  input  logic [RADDR_W-1:0]  rdMem,
  input  logic                flush,
  output logic                stall,
  mem_wb_stage_hs_if.master   mem,
  output logic                ORegWrite,
  output logic [STORE_W-1:0]  ORegStore,
  output logic [DATA_W-1:0]   OPCP2,
  output logic [DATA_W-1:0]   OALUResult,
  output logic [DATA_W-1:0]   OStoreMem,
  output logic [RADDR_W-1:0]  rdWB
);
  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e state_q, state_d;

  // Instruction fields captured when a memory op is issued.
  logic               lat_regwrite_q, lat_regwrite_d;
  logic [STORE_W-1:0] lat_regstore_q, lat_regstore_d;
  logic [DATA_W-1:0]  lat_pcp2_q,     lat_pcp2_d;
  logic [DATA_W-1:0]  lat_alu_q,      lat_alu_d;
  logic [RADDR_W-1:0] lat_rd_q,       lat_rd_d;
  logic               lat_read_q,     lat_read_d;
  logic               lat_byte_q,     lat_byte_d;
  logic               lat_signed_q,   lat_signed_d;

  // Memory bus drivers, held stable for the whole transaction.
  logic               mem_req_q,   mem_req_d;
  logic               mem_we_q,    mem_we_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]      mem_be_q,    mem_be_d;

  // MEM/WB pipeline register.
  logic               o_regwrite_q, o_regwrite_d;
  logic [STORE_W-1:0] o_regstore_q, o_regstore_d;
  logic [DATA_W-1:0]  o_pcp2_q,     o_pcp2_d;
  logic [DATA_W-1:0]  o_alu_q,      o_alu_d;
  logic [DATA_W-1:0]  o_storemem_q, o_storemem_d;
  logic [RADDR_W-1:0] o_rd_q,       o_rd_d;

  logic               memop;
  logic [LANE_W-1:0]  rd_lane;
  logic [DATA_W-1:0]  rd_shift;
  logic [7:0]         rd_byte;
  logic [DATA_W-1:0]  load_data;

  assign memop = in_valid & ~flush & (MemRead | MemWrite);

  // Hold upstream while issuing or waiting for ack; forced low during reset.
  always_comb begin
    stall = 1'b0;
    if (reset) begin
      stall = ((state_q == S_IDLE) & memop) | ((state_q == S_BUSY) & ~mem.mem_ack);
    end
  end

  // Select the addressed byte lane of the read data and extend it.
  always_comb begin
    rd_lane   = lat_alu_q[LANE_W-1:0];
    rd_shift  = mem.mem_rdata >> {rd_lane, 3'b000};
    rd_byte   = rd_shift[7:0];
    load_data = mem.mem_rdata;
    if (lat_byte_q) begin
      load_data = lat_signed_q ? {{(DATA_W-8){rd_byte[7]}}, rd_byte}
                               : {{(DATA_W-8){1'b0}}, rd_byte};
    end
  end

  // Next-state, issue and retire logic.
  always_comb begin
    state_d        = state_q;
    lat_regwrite_d = lat_regwrite_q;
    lat_regstore_d = lat_regstore_q;
    lat_pcp2_d     = lat_pcp2_q;
    lat_alu_d      = lat_alu_q;
    lat_rd_d       = lat_rd_q;
    lat_read_d     = lat_read_q;
    lat_byte_d     = lat_byte_q;
    lat_signed_d   = lat_signed_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    o_regwrite_d   = 1'b0;
    o_regstore_d   = o_regstore_q;
    o_pcp2_d       = o_pcp2_q;
    o_alu_d        = o_alu_q;
    o_storemem_d   = '0;
    o_rd_d         = o_rd_q;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          lat_regwrite_d = IRegWrite;
          lat_regstore_d = IRegStore;
          lat_pcp2_d     = IPCP2;
          lat_alu_d      = IALUResult;
          lat_rd_d       = rdMem;
          lat_read_d     = MemRead;
          lat_byte_d     = MemByte;
          lat_signed_d   = MemSigned;
          mem_req_d      = 1'b1;
          mem_we_d       = MemWrite;
          mem_wdata_d    = MemByte ? {NB{thirdArg[7:0]}} : thirdArg;
          mem_be_d       = MemByte ? ({{(NB-1){1'b0}}, 1'b1} << IALUResult[LANE_W-1:0]) : '1;
          state_d        = S_BUSY;
        end else begin
          o_regwrite_d = IRegWrite & in_valid & ~flush;
          o_regstore_d = IRegStore;
          o_pcp2_d     = IPCP2;
          o_alu_d      = IALUResult;
          o_rd_d       = rdMem;
        end
      end
      S_BUSY: begin
        if (mem.mem_ack) begin
          mem_req_d    = 1'b0;
          o_regwrite_d = lat_regwrite_q;
          o_regstore_d = lat_regstore_q;
          o_pcp2_d     = lat_pcp2_q;
          o_alu_d      = lat_alu_q;
          o_rd_d       = lat_rd_q;
          o_storemem_d = lat_read_q ? load_data : '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched fields, bus drivers and MEM/WB register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      lat_regwrite_q <= 1'b0;
      lat_regstore_q <= '0;
      lat_pcp2_q     <= '0;
      lat_alu_q      <= '0;
      lat_rd_q       <= '0;
      lat_read_q     <= 1'b0;
      lat_byte_q     <= 1'b0;
      lat_signed_q   <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      o_regwrite_q   <= 1'b0;
      o_regstore_q   <= '0;
      o_pcp2_q       <= '0;
      o_alu_q        <= '0;
      o_storemem_q   <= '0;
      o_rd_q         <= '0;
    end else begin
      state_q        <= state_d;
      lat_regwrite_q <= lat_regwrite_d;
      lat_regstore_q <= lat_regstore_d;
      lat_pcp2_q     <= lat_pcp2_d;
      lat_alu_q      <= lat_alu_d;
      lat_rd_q       <= lat_rd_d;
      lat_read_q     <= lat_read_d;
      lat_byte_q     <= lat_byte_d;
      lat_signed_q   <= lat_signed_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      o_regwrite_q   <= o_regwrite_d;
      o_regstore_q   <= o_regstore_d;
      o_pcp2_q       <= o_pcp2_d;
      o_alu_q        <= o_alu_d;
      o_storemem_q   <= o_storemem_d;
      o_rd_q         <= o_rd_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = lat_alu_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

  assign ORegWrite  = o_regwrite_q;
  assign ORegStore  = o_regstore_q;
  assign OPCP2      = o_pcp2_q;
  assign OALUResult = o_alu_q;
  assign OStoreMem  = o_storemem_q;
  assign rdWB       = o_rd_q;
endmodule
